router_reg_param: RTL
=====================

ROUTER_REG_PARAM -- requirements
Module: router_reg_param

Interface
REQ-001 Parameter: DATA_W, default 8, data width in bits (>= 4).
REQ-002 Parameter: SKID_DEPTH, default 2, entries in the fifo-full hold buffer (power of 2, >= 2).
REQ-003 Parameter: CHK_MODE, default 0, check mode: 0 = XOR parity, 1 = modulo-2^DATA_W additive checksum.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 pkt_valid  in  1  high while header/payload bytes are on data_in; low on the check byte.
REQ-007 data_in  in  DATA_W  packet byte.
REQ-008 detect_addr, lfd_state, ld_state, laf_state, full_state, rst_int_reg  in  1 each  controller FSM state strobes.
REQ-009 fifo_full  in  1  destination FIFO cannot accept a write this cycle.
REQ-010 dout  out  DATA_W  byte to destination FIFO.
REQ-011 dout_valid  out  1  FIFO write strobe qualifying dout.
REQ-012 low_pkt_valid  out  1  check byte received, packet input finished.
REQ-013 parity_done  out  1  check byte written to FIFO.
REQ-014 err  out  1  check mismatch.
REQ-015 len_err  out  1  payload count differs from header length field.
REQ-016 skid_ovf  out  1  sticky: byte dropped because hold buffer was full.
REQ-017 skid_count  out  clog2(SKID_DEPTH+1)  occupied hold-buffer entries.

Function
REQ-018 Header: detect_addr && pkt_valid SHALL load hdr_reg <= data_in, clear accumulator, payload counter, parity_done, err, len_err, skid_ovf.
REQ-019 Header length field SHALL be hdr_reg[DATA_W-1:2]; bits [1:0] are destination address, ignored here.
REQ-020 lfd_state SHALL drive dout <= hdr_reg, dout_valid = 1, accumulate hdr_reg.
REQ-021 Accumulate SHALL be acc <= acc ^ x (CHK_MODE 0) or acc <= acc + x truncated to DATA_W (CHK_MODE 1).
REQ-022 ld_state && pkt_valid SHALL accumulate data_in and increment payload counter (saturating at all-ones) once per byte, whether written or buffered.
REQ-023 ld_state, !fifo_full, hold buffer empty: dout <= data_in, dout_valid = 1 next cycle.
REQ-024 ld_state with fifo_full, or hold buffer non-empty: data_in SHALL be pushed to the hold buffer tail (FIFO order).
REQ-025 Drain: (laf_state or ld_state) && !fifo_full && buffer non-empty SHALL pop the head to dout with dout_valid = 1; simultaneous push and pop allowed, skid_count unchanged.
REQ-026 Push into full buffer without a same-cycle pop SHALL drop the byte and set skid_ovf; the byte still accumulates.
REQ-027 ld_state && !pkt_valid: check byte SHALL be latched into chk_reg and take the same write/hold path; not accumulated, not counted.
REQ-028 One cycle after check-byte capture: err <= (acc != chk_reg), len_err <= (payload counter != length field); both held until next header or reset.
REQ-029 parity_done SHALL set the cycle the check byte is written to dout and hold until next header or reset.
REQ-030 low_pkt_valid SHALL set on ld_state && !pkt_valid; rst_int_reg clears it with priority.
REQ-031 full_state SHALL suppress dout_valid and freeze hold buffer; header capture still operates.
REQ-032 dout_valid SHALL be low in every cycle not covered by REQ-020/023/025.
REQ-033 detect_addr during a non-empty buffer SHALL NOT discard buffered bytes.

Reset
REQ-034 reset SHALL zero dout, dout_valid, low_pkt_valid, parity_done, err, len_err, skid_ovf, skid_count, accumulator, counter, hdr_reg, chk_reg.
REQ-035 reset mid-packet SHALL discard buffer contents; first post-reset output requires a new header.

Verification (DATA_W=8, SKID_DEPTH=2)
REQ-036 CHK_MODE 0, header 0x0D, payload 11,22,33, check 0x0D, fifo_full=0 -> dout 0D,11,22,33,0D; err=0, len_err=0, parity_done=1.
REQ-037 Same, check 0x0C -> err=1 one cycle after capture; cleared on next header.
REQ-038 fifo_full high for 22,33 -> skid_count 1,2; after fifo_full falls and laf_state, dout 22 then 33 in order.
REQ-039 fifo_full high for 3 payload bytes -> third dropped, skid_ovf=1, err=0 with correct check byte.
REQ-040 CHK_MODE 1, header 0x09, payload F0,20, check 0x19 -> err=0; header 0x0D same bytes -> len_err=1.
REQ-041 reset asserted with skid_count=2 -> all outputs 0 next cycle; rst_int_reg with ld_state && !pkt_valid -> low_pkt_valid=0.

Source files
------------

// File: rtl/router_reg_param.sv
// Router datapath register: header/payload forwarding with running check, length check and a small hold buffer.
// Latency: one cycle input to dout. Backpressure: fifo_full diverts bytes into a SKID_DEPTH-entry hold buffer; overflow drops and flags skid_ovf.
module router_reg_param #(
    parameter int DATA_W     = 8,
    parameter int SKID_DEPTH = 2,
    parameter int CHK_MODE   = 0
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              pkt_valid,
    input  logic [DATA_W-1:0]                 data_in,
    input  logic                              detect_addr,
    input  logic                              lfd_state,
    input  logic                              ld_state,
    input  logic                              laf_state,
    input  logic                              full_state,
    input  logic                              rst_int_reg,
    input  logic                              fifo_full,
    output logic [DATA_W-1:0]                 dout,
    output logic                              dout_valid,
    output logic                              low_pkt_valid,
    output logic                              parity_done,
    output logic                              err,
    output logic                              len_err,
    output logic                              skid_ovf,
    output logic [$clog2(SKID_DEPTH+1)-1:0]   skid_count
);
    localparam int CNT_W = $clog2(SKID_DEPTH + 1);
    localparam int PTR_W = $clog2(SKID_DEPTH);

    logic [DATA_W-1:0] hdr_reg;
    logic [DATA_W-1:0] chk_reg;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] pay_cnt;
    logic              chk_pending;

    // Each entry carries a flag marking the check byte so parity_done fires when it leaves.
    logic [DATA_W:0]   mem [SKID_DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;

    logic buf_empty, buf_full, take, pop, direct, push, push_ok, drop;

    function automatic logic [DATA_W-1:0] acc_next(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] x);
        if (CHK_MODE == 0) return a ^ x;
        else               return a + x;
    endfunction

    always_comb begin
        buf_empty = (skid_count == '0);
        buf_full  = (skid_count == CNT_W'(SKID_DEPTH));
        take      = ld_state && !full_state;
        pop       = (laf_state || ld_state) && !fifo_full && !buf_empty && !full_state;
        direct    = take && !fifo_full && buf_empty;
        push      = take && (fifo_full || !buf_empty);
        push_ok   = push && (!buf_full || pop);
        drop      = push && buf_full && !pop;
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= {!pkt_valid, data_in};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dout          <= '0;
            dout_valid    <= 1'b0;
            low_pkt_valid <= 1'b0;
            parity_done   <= 1'b0;
            err           <= 1'b0;
            len_err       <= 1'b0;
            skid_ovf      <= 1'b0;
            skid_count    <= '0;
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            hdr_reg       <= '0;
            chk_reg       <= '0;
            acc           <= '0;
            pay_cnt       <= '0;
            chk_pending   <= 1'b0;
        end else begin
            dout_valid <= 1'b0;
            if (lfd_state && !full_state) begin
                dout       <= hdr_reg;
                dout_valid <= 1'b1;
            end else if (pop) begin
                dout       <= mem[rd_ptr][DATA_W-1:0];
                dout_valid <= 1'b1;
                if (mem[rd_ptr][DATA_W])
                    parity_done <= 1'b1;
            end else if (direct) begin
                dout       <= data_in;
                dout_valid <= 1'b1;
                if (!pkt_valid)
                    parity_done <= 1'b1;
            end

            if (push_ok)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            skid_count <= skid_count + CNT_W'(push_ok) - CNT_W'(pop);
            if (drop)
                skid_ovf <= 1'b1;

            // acc/chk_reg are stable by now: the check byte itself is never accumulated.
            if (chk_pending) begin
                err     <= (acc != chk_reg);
                len_err <= (pay_cnt != {2'b00, hdr_reg[DATA_W-1:2]});
            end
            chk_pending <= ld_state && !pkt_valid;
            if (ld_state && !pkt_valid)
                chk_reg <= data_in;

            if (lfd_state) begin
                acc <= acc_next(acc, hdr_reg);
            end else if (ld_state && pkt_valid) begin
                acc <= acc_next(acc, data_in);
                if (pay_cnt != '1)
                    pay_cnt <= pay_cnt + DATA_W'(1);
            end

            if (rst_int_reg)
                low_pkt_valid <= 1'b0;
            else if (ld_state && !pkt_valid)
                low_pkt_valid <= 1'b1;

            // A new header wins over every per-packet status update above.
            if (detect_addr && pkt_valid) begin
                hdr_reg     <= data_in;
                acc         <= '0;
                pay_cnt     <= '0;
                parity_done <= 1'b0;
                err         <= 1'b0;
                len_err     <= 1'b0;
                skid_ovf    <= 1'b0;
                chk_pending <= 1'b0;
            end
        end
    end
endmodule
